// File: rtl/mux_pkg.sv
// Shared constants and types for the N:1 TDM selector path (mux and demux).
package mux_pkg;

    localparam int unsigned M = 2;
    localparam int unsigned N = 2 ** M;

    typedef enum logic {
        IDLE    = 1'b0,
        COLLECT = 1'b1
    } state_t;

    typedef logic [M-1:0] slot_t;

endpackage

// File: rtl/tdm_slot_counter.sv
// Slot index counter: synchronous load-to-1, wrap-to-0 and increment, with a terminal flag at N-1.
module tdm_slot_counter #(
    parameter int unsigned M = mux_pkg::M,
    parameter int unsigned N = 2 ** M
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load1,
    input  logic         inc,
    input  logic         wrap,
    output logic [M-1:0] cnt,
    output logic         term_c
);

    // Load wins over wrap, wrap wins over increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load1) begin
            cnt <= M'(1);
        end else if (wrap) begin
            cnt <= '0;
        end else if (inc) begin
            cnt <= cnt + M'(1);
        end
    end

    assign term_c = (cnt == M'(N - 1));

endmodule

// File: rtl/tdm_demux_1xn.sv
// Serial TDM demultiplexer: rebuilds an N-bit word from one bit per slot, slot k into bit k.
module tdm_demux_1xn #(
    parameter int unsigned M = mux_pkg::M,
    parameter int unsigned N = 2 ** M
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         din,
    input  logic         din_valid,
    input  logic         sof,
    output logic [N-1:0] frame,
    output logic         frame_valid,
    output logic [M-1:0] slot,
    output logic         busy,
    output logic         err
);

    import mux_pkg::*;

    state_t       state, state_d;
    // Slot N-1 is never stored: it goes straight into frame on completion.
    logic [N-2:0] shadow, shadow_d;
    logic [N-1:0] frame_d;
    logic         frame_valid_d;
    logic         busy_d;
    logic         err_d;
    logic         cnt_load1;
    logic         cnt_inc;
    logic         cnt_wrap;
    logic         term_c;

    tdm_slot_counter #(
        .M (M),
        .N (N)
    ) u_slot_counter (
        .clk    (clk),
        .rst_n  (rst_n),
        .load1  (cnt_load1),
        .inc    (cnt_inc),
        .wrap   (cnt_wrap),
        .cnt    (slot),
        .term_c (term_c)
    );

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            shadow      <= '0;
            frame       <= '0;
            frame_valid <= 1'b0;
            busy        <= 1'b0;
            err         <= 1'b0;
        end else begin
            state       <= state_d;
            shadow      <= shadow_d;
            frame       <= frame_d;
            frame_valid <= frame_valid_d;
            busy        <= busy_d;
            err         <= err_d;
        end
    end

    // Next-state and output logic; an sof beat always restarts at slot 0.
    always_comb begin
        state_d       = state;
        shadow_d      = shadow;
        frame_d       = frame;
        frame_valid_d = 1'b0;
        err_d         = 1'b0;
        cnt_load1     = 1'b0;
        cnt_inc       = 1'b0;
        cnt_wrap      = 1'b0;

        if (din_valid) begin
            if (sof) begin
                err_d       = (state == COLLECT);
                shadow_d    = '0;
                shadow_d[0] = din;
                cnt_load1   = 1'b1;
                state_d     = COLLECT;
            end else if (state == COLLECT) begin
                if (term_c) begin
                    frame_d       = {din, shadow};
                    frame_valid_d = 1'b1;
                    cnt_wrap      = 1'b1;
                    state_d       = IDLE;
                end else begin
                    shadow_d[slot] = din;
                    cnt_inc        = 1'b1;
                end
            end
        end

        busy_d = (state_d == COLLECT);
    end

endmodule

// File: tb/tb_tdm_demux_1xn.sv
// Self-checking bench for tdm_demux_1xn: directed frames plus random beats against a queue-based model.
module tb_tdm_demux_1xn;

    localparam int unsigned M = 2;
    localparam int unsigned N = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         din = 1'b0;
    logic         din_valid = 1'b0;
    logic         sof = 1'b0;
    logic [N-1:0] frame;
    logic         frame_valid;
    logic [M-1:0] slot;
    logic         busy;
    logic         err;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: bits received so far in the open frame; empty means idle.
    int bits_q[$];
    int exp_frame = 0;
    int exp_fv    = 0;
    int exp_err   = 0;
    int fv_seen   = 0;
    int fv_exp    = 0;

    tdm_demux_1xn #(.M(M), .N(N)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .din         (din),
        .din_valid   (din_valid),
        .sof         (sof),
        .frame       (frame),
        .frame_valid (frame_valid),
        .slot        (slot),
        .busy        (busy),
        .err         (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_outputs();
        check("frame",       32'(frame),       32'(exp_frame));
        check("frame_valid", 32'(frame_valid), 32'(exp_fv));
        check("slot",        32'(slot),        32'(bits_q.size()));
        check("busy",        32'(busy),        32'(bits_q.size() != 0));
        check("err",         32'(err),         32'(exp_err));
        if (frame_valid && err) check("fv_err_exclusive", 32'(1), 32'(0));
    endtask

    // One clock: present inputs, let the model see the accepted beat, compare on the falling edge.
    task automatic cycle(input logic v, input logic s, input logic d);
        int w;
        din_valid = v;
        sof       = s;
        din       = d;
        @(posedge clk);
        exp_fv  = 0;
        exp_err = 0;
        if (v) begin
            if (s) begin
                if (bits_q.size() != 0) exp_err = 1;
                bits_q = {};
                bits_q.push_back(int'(d));
            end else if (bits_q.size() != 0) begin
                bits_q.push_back(int'(d));
            end
            if (bits_q.size() == N) begin
                w = 0;
                foreach (bits_q[k]) w += bits_q[k] << k;
                exp_frame = w;
                exp_fv    = 1;
                fv_exp++;
                bits_q = {};
            end
        end
        @(negedge clk);
        if (frame_valid) fv_seen++;
        check_outputs();
    endtask

    task automatic send_frame(input logic [N-1:0] word, input int gap);
        for (int k = 0; k < N; k++) begin
            cycle(1'b1, k == 0, word[k]);
            for (int g = 0; g < gap; g++) cycle(1'b0, 1'($urandom), 1'($urandom));
        end
    endtask

    // Asynchronous reset pulse taken between clock edges; outputs must clear at once.
    task automatic pulse_reset();
        rst_n = 1'b0;
        #1;
        bits_q    = {};
        exp_frame = 0;
        exp_fv    = 0;
        exp_err   = 0;
        check_outputs();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [N-1:0] w;
        #1;
        check_outputs();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Contiguous frame 1,0,1,1 -> 4'b1101.
        send_frame(4'b1101, 0);
        check("t1_frame", 32'(frame), 32'h0000_000d);
        cycle(1'b0, 1'b0, 1'b0);

        // Same frame with 3-cycle gaps.
        send_frame(4'b1101, 3);
        cycle(1'b0, 1'b0, 1'b0);

        // Abort on the third beat, restart with 1,1,1,1.
        cycle(1'b1, 1'b1, 1'b0);
        cycle(1'b1, 1'b0, 1'b1);
        cycle(1'b1, 1'b1, 1'b1);
        cycle(1'b1, 1'b0, 1'b1);
        cycle(1'b1, 1'b0, 1'b1);
        cycle(1'b1, 1'b0, 1'b1);
        check("t3_frame", 32'(frame), 32'h0000_000f);

        // Back-to-back frames, no idle cycle.
        send_frame(4'hA, 0);
        check("t4_frame_a", 32'(frame), 32'h0000_000a);
        send_frame(4'h5, 0);
        check("t4_frame_5", 32'(frame), 32'h0000_0005);

        // Valid beats without sof while idle are discarded.
        for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 1'($urandom));

        // Abort on the would-be last slot.
        cycle(1'b1, 1'b1, 1'b1);
        cycle(1'b1, 1'b0, 1'b1);
        cycle(1'b1, 1'b0, 1'b1);
        cycle(1'b1, 1'b1, 1'b0);
        send_frame(4'h6, 1);

        // Reset two beats into a frame, then a clean frame.
        cycle(1'b1, 1'b1, 1'b1);
        cycle(1'b1, 1'b0, 1'b1);
        pulse_reset();
        cycle(1'b1, 1'b0, 1'b1);
        send_frame(4'h3, 0);
        check("t6_frame", 32'(frame), 32'h0000_0003);

        // Random beats: mixed valid gaps, early sofs and whole frames.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 9) == 0) begin
                w = 4'($urandom);
                send_frame(w, $urandom_range(0, 2));
            end else begin
                cycle(1'($urandom_range(0, 3) != 0), $urandom_range(0, 5) == 0, 1'($urandom));
            end
        end

        check("fv_pulse_count", 32'(fv_seen), 32'(fv_exp));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
